// File: rtl/btn_cmd_pkg.sv
// btn_cmd_pkg: command codes, widths and round-robin helper for the button front-end
package btn_cmd_pkg;
  localparam int NUM_BTN = 4;
  localparam int CODE_W = 2;
  typedef enum logic [CODE_W-1:0] {CMD_R = 2'd0, CMD_U = 2'd1, CMD_D = 2'd2, CMD_L = 2'd3} cmd_e;
  // Returns {found, index} of the first set request at or after ptr, wrapping.
  function automatic logic [CODE_W:0] rr_pick(input logic [NUM_BTN-1:0] req, input logic [CODE_W-1:0] ptr);
    rr_pick = '0;
    for (int k = NUM_BTN - 1; k >= 0; k--)
      if (req[ptr + CODE_W'(k)]) rr_pick = {1'b1, ptr + CODE_W'(k)};
  endfunction
endpackage

// File: rtl/btn_cmd_arbiter_if.sv
// btn_cmd_arbiter_if: command stream handshake plus queue status
interface btn_cmd_arbiter_if #(parameter int QUEUE_DEPTH = 4);
  localparam int LW = $clog2(QUEUE_DEPTH + 1);
  logic cmd_valid;
  logic [btn_cmd_pkg::CODE_W-1:0] cmd_code;
  logic cmd_ready;
  logic [LW-1:0] queue_level;
  logic [7:0] drop_cnt;
  modport master(output cmd_valid, cmd_code, queue_level, drop_cnt, input cmd_ready);
  modport slave(input cmd_valid, cmd_code, queue_level, drop_cnt, output cmd_ready);
endinterface

// File: rtl/btn_debounce_onepulse.sv
// btn_debounce_onepulse: shift-register debouncer with rising-edge one-pulse
module btn_debounce_onepulse #(parameter int DEBOUNCE_LEN = 4) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic level,
  output logic pulse
);
  logic [DEBOUNCE_LEN-1:0] sr;
  logic deb_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sr <= '0;
      level <= 1'b0;
      deb_q <= 1'b0;
    end else begin
      sr <= {sr[DEBOUNCE_LEN-2:0], btn_in};
      level <= &sr ? 1'b1 : ~|sr ? 1'b0 : level;
      deb_q <= level;
    end
  assign pulse = level & ~deb_q;
endmodule

// File: rtl/btn_cmd_arbiter.sv
// btn_cmd_arbiter: debounced button presses, round-robin arbitrated into a command FIFO
module btn_cmd_arbiter import btn_cmd_pkg::*; #(
  parameter int DEBOUNCE_LEN = 4,
  parameter int QUEUE_DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic BTNR,
  input  logic BTNU,
  input  logic BTND,
  input  logic BTNL,
  btn_cmd_arbiter_if.master cmd
);
  localparam int AW = $clog2(QUEUE_DEPTH);
  localparam int LW = $clog2(QUEUE_DEPTH + 1);
  logic [NUM_BTN-1:0] raw, deb, press, pending, gmask, drop_v;
  logic [CODE_W-1:0] ptr, gidx;
  logic [CODE_W-1:0] mem [QUEUE_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [LW-1:0] level_q;
  logic [7:0] drops;
  logic [8:0] dsum;
  logic [CODE_W:0] pick;
  logic gnt, pop;
  assign raw = {BTNL, BTND, BTNU, BTNR};
  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    btn_debounce_onepulse #(.DEBOUNCE_LEN(DEBOUNCE_LEN)) u_deb (
      .clk(clk), .rst(rst), .btn_in(raw[i]), .level(deb[i]), .pulse(press[i])
    );
  end
  // Fullness uses the registered level, so a same-cycle pop never frees a slot.
  always_comb begin
    pick = rr_pick(pending, ptr);
    gnt = pick[CODE_W] && level_q != LW'(QUEUE_DEPTH);
    gidx = pick[CODE_W-1:0];
    gmask = gnt ? NUM_BTN'(1) << gidx : '0;
    drop_v = press & pending & ~gmask;
    pop = level_q != '0 && cmd.cmd_ready;
    dsum = 9'(drops) + 9'($countones(drop_v));
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pending <= '0;
      ptr <= CMD_R;
      wp <= '0;
      rp <= '0;
      level_q <= '0;
      drops <= '0;
      for (int k = 0; k < QUEUE_DEPTH; k++) mem[k] <= '0;
    end else begin
      pending <= (pending & ~gmask) | press;
      if (gnt) begin
        mem[wp] <= gidx;
        wp <= wp + 1'b1;
        ptr <= gidx + 1'b1;
      end
      if (pop) rp <= rp + 1'b1;
      level_q <= level_q + LW'(gnt) - LW'(pop);
      drops <= dsum[8] ? 8'hff : dsum[7:0];
    end
  assign cmd.cmd_valid = level_q != '0;
  assign cmd.cmd_code = mem[rp];
  assign cmd.queue_level = level_q;
  assign cmd.drop_cnt = drops;
  logic unused_deb;
  assign unused_deb = ^deb;
endmodule

// File: tb/tb_btn_cmd_arbiter.sv
// tb_btn_cmd_arbiter: directed scenarios plus random buttons against a behavioural model
module tb_btn_cmd_arbiter;
  localparam int L = 4, D = 4;
  logic clk = 1'b0, rst = 1'b1, br = 1'b0, bu = 1'b0, bd = 1'b0, bl = 1'b0;
  btn_cmd_arbiter_if #(.QUEUE_DEPTH(D)) cmd();
  btn_cmd_arbiter #(.DEBOUNCE_LEN(L), .QUEUE_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .BTNR(br), .BTNU(bu), .BTND(bd), .BTNL(bl), .cmd(cmd)
  );
  always #5 clk = ~clk;
  int n_cmp = 0, n_err = 0;
  int m_run[4], m_last[4], m_deb[4], m_debq[4], m_pend[4];
  int m_ptr, m_drop;
  int m_q[$];
  int popped[$];
  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_run[i] = L; m_last[i] = 0; m_deb[i] = 0; m_debq[i] = 0; m_pend[i] = 0;
    end
    m_ptr = 0; m_drop = 0; m_q.delete();
  endtask
  // A level is accepted once L identical samples have been seen; presses are rising accepted levels.
  task automatic model_step();
    int raw[4];
    int g;
    bit pop, press;
    raw = '{int'(br), int'(bu), int'(bd), int'(bl)};
    g = -1;
    if (m_q.size() < D)
      for (int k = 0; k < 4; k++) if (g < 0 && m_pend[(m_ptr + k) % 4] != 0) g = (m_ptr + k) % 4;
    pop = m_q.size() > 0 && cmd.cmd_ready;
    for (int i = 0; i < 4; i++) begin
      press = m_deb[i] == 1 && m_debq[i] == 0;
      if (press && m_pend[i] != 0 && g != i && m_drop < 255) m_drop++;
      if (g == i) m_pend[i] = int'(press);
      else if (press) m_pend[i] = 1;
      m_debq[i] = m_deb[i];
      if (m_run[i] >= L) m_deb[i] = m_last[i];
      if (raw[i] == m_last[i]) begin
        if (m_run[i] < L) m_run[i]++;
      end else begin
        m_last[i] = raw[i]; m_run[i] = 1;
      end
    end
    if (pop) void'(m_q.pop_front());
    if (g >= 0) begin
      m_q.push_back(g);
      m_ptr = (g + 1) % 4;
    end
  endtask
  always @(posedge clk or posedge rst)
    if (rst) model_reset();
    else model_step();
  always @(posedge clk)
    if (!rst && cmd.cmd_valid === 1'b1 && cmd.cmd_ready) popped.push_back(int'(cmd.cmd_code));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(negedge clk);
    chk("m_valid", cmd.cmd_valid, m_q.size() != 0);
    chk("m_level", cmd.queue_level, m_q.size());
    chk("m_drop", cmd.drop_cnt, m_drop);
    if (m_q.size() != 0) chk("m_code", cmd.cmd_code, m_q[0]);
  endtask
  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask
  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
  endtask
  initial begin
    int n0;
    int hold[4];
    bit rv[4];
    int rhold;
    cmd.cmd_ready = 1'b1;
    model_reset();
    for (int k = 0; k < 5; k++) begin
      {br, bu, bd, bl} = 4'($urandom);
      step();
      chk("rst_valid", cmd.cmd_valid, 0);
      chk("rst_level", cmd.queue_level, 0);
      chk("rst_drop", cmd.drop_cnt, 0);
    end
    {br, bu, bd, bl} = 4'b0;
    rst = 1'b0;
    steps(6);
    chk("post_rst_valid", cmd.cmd_valid, 0);
    chk("post_rst_level", cmd.queue_level, 0);
    n0 = popped.size();
    br = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      chk("single_early_valid", cmd.cmd_valid, 0);
    end
    step();
    chk("single_valid_e6", cmd.cmd_valid, 1);
    chk("single_code", cmd.cmd_code, 0);
    steps(3);
    br = 1'b0;
    steps(12);
    chk("single_count", popped.size() - n0, 1);
    chk("single_level", cmd.queue_level, 0);
    n0 = popped.size();
    bu = 1'b1;
    steps(3);
    bu = 1'b0;
    steps(12);
    chk("glitch_count", popped.size() - n0, 0);
    chk("glitch_level", cmd.queue_level, 0);
    do_reset();
    cmd.cmd_ready = 1'b0;
    {bu, bd, bl} = 3'b111;
    steps(7);
    chk("simul_lvl1", cmd.queue_level, 1);
    chk("simul_head", cmd.cmd_code, 1);
    step();
    chk("simul_lvl2", cmd.queue_level, 2);
    step();
    chk("simul_lvl3", cmd.queue_level, 3);
    steps(3);
    {bu, bd, bl} = 3'b000;
    steps(10);
    chk("simul_hold", cmd.queue_level, 3);
    n0 = popped.size();
    cmd.cmd_ready = 1'b1;
    steps(6);
    chk("simul_pops", popped.size() - n0, 3);
    for (int k = 0; k < 3; k++) chk("simul_order", popped[n0 + k], k + 1);
    cmd.cmd_ready = 1'b0;
    {bu, bd, bl} = 3'b111;
    steps(12);
    {bu, bd, bl} = 3'b000;
    steps(10);
    chk("pre_rst_level", cmd.queue_level, 3);
    #2 rst = 1'b1;
    #1;
    chk("async_valid", cmd.cmd_valid, 0);
    chk("async_level", cmd.queue_level, 0);
    @(negedge clk);
    rst = 1'b0;
    steps(2);
    cmd.cmd_ready = 1'b1;
    br = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      chk("rearm_early_valid", cmd.cmd_valid, 0);
    end
    step();
    chk("rearm_valid_e6", cmd.cmd_valid, 1);
    chk("rearm_code", cmd.cmd_code, 0);
    br = 1'b0;
    steps(10);
    do_reset();
    cmd.cmd_ready = 1'b0;
    for (int p = 1; p <= 6; p++) begin
      br = 1'b1;
      steps(8);
      br = 1'b0;
      steps(8);
      if (p == 5) chk("bp_full", cmd.queue_level, 4);
    end
    chk("bp_drop", cmd.drop_cnt, 1);
    chk("bp_level", cmd.queue_level, 4);
    n0 = popped.size();
    cmd.cmd_ready = 1'b1;
    steps(12);
    chk("bp_drained", popped.size() - n0, 5);
    for (int k = 0; k < 5; k++) chk("bp_code", popped[n0 + k], 0);
    chk("bp_empty", cmd.queue_level, 0);
    for (int i = 0; i < 4; i++) begin
      hold[i] = 1; rv[i] = 1'b0;
    end
    rhold = 1;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 4; i++)
        if (--hold[i] == 0) begin
          rv[i] = ~rv[i];
          hold[i] = $urandom_range(1, 10);
        end
      if (--rhold == 0) begin
        cmd.cmd_ready = $urandom_range(0, 1) == 1;
        rhold = $urandom_range(1, 30);
      end
      {br, bu, bd, bl} = {rv[0], rv[1], rv[2], rv[3]};
      rst = $urandom_range(0, 599) == 0;
      step();
    end
    rst = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
